// File: rtl/alu_mux.sv
// ALU operand-B select: forwarding mux for the register path, immediate select,
// plus a stallable/flushable registered copy of SrcB and store data.
module alu_mux #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] RD2,
    input  logic [WIDTH-1:0] ImmExt,
    input  logic             ALUSrc,
    input  logic [1:0]       ForwardB,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] ResultW,
    input  logic             en,
    input  logic             flush,
    output logic [WIDTH-1:0] SrcB,
    output logic [WIDTH-1:0] WriteData,
    output logic [WIDTH-1:0] SrcB_q,
    output logic [WIDTH-1:0] WriteData_q
);

    logic [WIDTH-1:0] regb;

    // Reserved select 11 falls to RD2 so no encoding can produce X.
    always_comb begin
        regb = RD2;
        case (ForwardB)
            2'b01:   regb = ResultW;
            2'b10:   regb = ALUResultM;
            default: regb = RD2;
        endcase
    end

    assign WriteData = regb;
    assign SrcB      = ALUSrc ? ImmExt : regb;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            SrcB_q      <= '0;
            WriteData_q <= '0;
        end else if (en) begin
            SrcB_q      <= SrcB;
            WriteData_q <= WriteData;
        end
    end

endmodule

// File: tb/tb_alu_mux.sv
// Randomized self-checking bench for alu_mux against a table-lookup reference model.
module tb_alu_mux;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, ALUSrc, en, flush;
    logic [1:0]   ForwardB;
    logic [W-1:0] RD2, ImmExt, ALUResultM, ResultW;
    logic [W-1:0] SrcB, WriteData, SrcB_q, WriteData_q;

    int nvec = 0;
    int nerr = 0;
    logic [W-1:0] mq_s, mq_w;

    always #5 clk = ~clk;

    alu_mux #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .RD2(RD2), .ImmExt(ImmExt), .ALUSrc(ALUSrc),
        .ForwardB(ForwardB), .ALUResultM(ALUResultM), .ResultW(ResultW),
        .en(en), .flush(flush), .SrcB(SrcB), .WriteData(WriteData),
        .SrcB_q(SrcB_q), .WriteData_q(WriteData_q)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Forward sources indexed directly by ForwardB; reserved slot aliases RD2.
    function automatic logic [W-1:0] m_regb();
        logic [W-1:0] src [4];
        src[0] = RD2; src[1] = ResultW; src[2] = ALUResultM; src[3] = RD2;
        return src[ForwardB];
    endfunction

    function automatic logic [W-1:0] m_srcb();
        return ALUSrc ? ImmExt : m_regb();
    endfunction

    task automatic drive(input logic [W-1:0] rd2, input logic [W-1:0] imm, input logic asrc,
                         input logic [1:0] fb, input logic [W-1:0] alum, input logic [W-1:0] resw,
                         input logic e, input logic fl, input logic r);
        RD2 = rd2; ImmExt = imm; ALUSrc = asrc; ForwardB = fb;
        ALUResultM = alum; ResultW = resw; en = e; flush = fl; rst = r;
        #1;
        chk("srcb_comb", SrcB, m_srcb());
        chk("wdata_comb", WriteData, m_regb());
    endtask

    task automatic tick();
        if (rst || flush) begin
            mq_s = '0; mq_w = '0;
        end else if (en) begin
            mq_s = m_srcb(); mq_w = m_regb();
        end
        @(posedge clk);
        #1;
        chk("srcb_q", SrcB_q, mq_s);
        chk("wdata_q", WriteData_q, mq_w);
    endtask

    initial begin
        mq_s = '0; mq_w = '0;
        // Reset, with combinational path checked while rst is high
        drive(32'hAAAA_AAAA, 32'h1234_5678, 1'b0, 2'b00, 32'h1111_1111, 32'h2222_2222, 1'b1, 1'b0, 1'b1);
        tick();
        chk("reset_srcb_q", SrcB_q, '0);

        // Directed combinational cases, no clock edge needed
        drive(32'hAAAA_AAAA, 32'h1234_5678, 1'b0, 2'b00, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        drive(32'hAAAA_AAAA, 32'h1234_5678, 1'b1, 2'b00, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        drive(32'hDEAD_BEEF, 32'hBEEF_DEAD, 1'b0, 2'b00, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        drive(32'hDEAD_BEEF, 32'hBEEF_DEAD, 1'b1, 2'b00, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 1'b0);
        for (int a = 0; a < 2; a++)
            for (int f = 0; f < 4; f++)
                drive(32'h3333_3333, 32'h4444_4444, a[0], f[1:0], 32'h1111_1111, 32'h2222_2222,
                      1'b0, 1'b0, 1'b0);
        // Hold check: q must still be zero after all those en=0 input changes
        tick();

        // Capture, stall, flush, reset priority
        drive(32'hDEAD_BEEF, 32'h0, 1'b0, 2'b00, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        tick();
        chk("capture_deadbeef", SrcB_q, 32'hDEAD_BEEF);
        drive(32'h0BAD_F00D, 32'h5, 1'b1, 2'b10, 32'h7, 32'h9, 1'b0, 1'b0, 1'b0);
        tick();
        chk("stall_hold", SrcB_q, 32'hDEAD_BEEF);
        drive(32'h0BAD_F00D, 32'h5, 1'b1, 2'b10, 32'h7, 32'h9, 1'b1, 1'b1, 1'b0);
        tick();
        chk("flush_clear", SrcB_q, '0);
        drive(32'hCAFE_0001, 32'h5, 1'b0, 2'b00, 32'h7, 32'h9, 1'b1, 1'b0, 1'b0);
        tick();
        drive(32'hCAFE_0002, 32'h5, 1'b0, 2'b00, 32'h7, 32'h9, 1'b1, 1'b0, 1'b1);
        tick();
        chk("rst_over_en", WriteData_q, '0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive($urandom, $urandom, 1'($urandom), 2'($urandom), $urandom, $urandom,
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
                  ($urandom_range(0, 19) == 0));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
